// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          MAX_BUS_W = 1024;

  // Bubble payload: instruction slot holds instr (truncated to data_w), all other fields zero.
  function automatic logic [MAX_BUS_W-1:0] bubble_word(input int num_fields, input int data_w,
                                                       input logic [31:0] instr);
    logic [MAX_BUS_W-1:0] w;
    w = '0;
    for (int k = 0; k < MAX_BUS_W; k++) begin
      if (k < data_w && k < 32 && k < num_fields * data_w) w[k] = instr[k[4:0]];
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the elastic stage: load enable plus synchronous clear to a fixed pattern.
module pipe_slot #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 2,
  parameter logic [DATA_W*NUM_FIELDS-1:0] CLR_VAL = '0
) (
  input  logic                         iClk,
  input  logic                         iClr,
  input  logic                         iLoad,
  input  logic [DATA_W*NUM_FIELDS-1:0] iData,
  output logic [DATA_W*NUM_FIELDS-1:0] oData
);

  logic [DATA_W*NUM_FIELDS-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (iClr)       data_d = CLR_VAL;
    else if (iLoad) data_d = iData;
  end

  always_ff @(posedge iClk) begin
    data_q <= data_d;
  end

  assign oData = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          NUM_FIELDS   = 2,
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR,
  parameter int          CNT_W        = 16
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iFlush,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic [DATA_W*NUM_FIELDS-1:0] iData,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [DATA_W*NUM_FIELDS-1:0] oData,
  output logic [CNT_W-1:0]             oStallCount
);

  localparam int                    BUS_W       = DATA_W * NUM_FIELDS;
  localparam logic [MAX_BUS_W-1:0]  BUBBLE_FULL = bubble_word(NUM_FIELDS, DATA_W, BUBBLE_INSTR);
  localparam logic [BUS_W-1:0]      BUBBLE      = BUBBLE_FULL[BUS_W-1:0];
  localparam logic [CNT_W-1:0]      CNT_MAX     = '1;

  pipe_state_t      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept, emit;
  logic             main_ld, main_clr, skid_ld, sel_skid;
  logic [BUS_W-1:0] main_din, main_data, skid_data;

  assign accept = iValid && (state_q != TWO);
  assign emit   = (state_q != EMPTY) && iReady;

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    sel_skid = 1'b0;
    if (iRst || iFlush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (emit) begin
            // Going empty: the output must show the bubble, not the stale word.
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          if (emit) begin
            state_d  = ONE;
            main_ld  = 1'b1;
            sel_skid = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (oValid && !iReady && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign main_din = sel_skid ? skid_data : iData;

  pipe_slot #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CLR_VAL(BUBBLE)) u_main (
    .iClk  (iClk),
    .iClr  (main_clr),
    .iLoad (main_ld),
    .iData (main_din),
    .oData (main_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CLR_VAL('0)) u_skid (
    .iClk  (iClk),
    .iClr  (iRst),
    .iLoad (skid_ld),
    .iData (iData),
    .oData (skid_data)
  );

  assign oValid      = (state_q != EMPTY);
  assign oReady      = (state_q != TWO);
  assign oData       = main_data;
  assign oStallCount = cnt_q;

  // Upstream must keep offering the same word while it is being back-pressured.
  a_upstream_hold: assert property (@(posedge iClk) disable iff (iRst)
    (iValid && !oReady && !iFlush) |=> (iValid && $stable(iData)));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomized bench for pipe_stage_elastic against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int DATA_W     = 32;
  localparam int NUM_FIELDS = 2;
  localparam int CNT_W      = 4;
  localparam int BUS_W      = DATA_W * NUM_FIELDS;
  localparam logic [BUS_W-1:0] BUBBLE  = {32'h0, 32'h00000013};
  localparam int               CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic             out_ready, out_valid;
  logic [BUS_W-1:0] in_data, out_data;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the stage as an ordered list plus a stall count.
  logic [BUS_W-1:0] mq[$];
  int               mcnt = 0;
  logic             last_ready_pre;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .BUBBLE_INSTR(32'h00000013), .CNT_W(CNT_W)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iFlush      (flush),
    .iValid      (in_valid),
    .oReady      (out_ready),
    .iData       (in_data),
    .oValid      (out_valid),
    .iReady      (in_ready),
    .oData       (out_data),
    .oStallCount (stall_cnt)
  );

  function automatic logic [BUS_W-1:0] word(input logic [31:0] pc);
    return {pc + 32'd4, pc};
  endfunction

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [BUS_W-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : BUBBLE;
    chk("model_valid", BUS_W'(out_valid), BUS_W'(mq.size() > 0));
    chk("model_ready", BUS_W'(out_ready), BUS_W'(mq.size() < 2));
    chk("model_data",  out_data, exp_data);
    chk("model_cnt",   BUS_W'(stall_cnt), BUS_W'(mcnt));
  endtask

  task automatic step(input logic v, input logic [BUS_W-1:0] d, input logic r,
                      input logic f, input logic rs);
    int pre_n;
    in_valid = v;
    in_data  = d;
    in_ready = r;
    flush    = f;
    rst      = rs;
    @(posedge clk);
    pre_n          = mq.size();
    last_ready_pre = (pre_n < 2);
    if (rs) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (pre_n > 0 && !r && mcnt < CNT_SAT) mcnt++;
      if (f) begin
        mq.delete();
      end else begin
        if (pre_n > 0 && r) void'(mq.pop_front());
        if (v && pre_n < 2) mq.push_back(d);
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    logic             v, r, f, rs, hold;
    logic [BUS_W-1:0] d;
    in_valid = 1'b0; in_data = '0; in_ready = 1'b0; flush = 1'b0; rst = 1'b1;

    // Reset then idle
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 0);
    chk("rst_valid", BUS_W'(out_valid), '0);
    chk("rst_ready", BUS_W'(out_ready), BUS_W'(1));
    chk("rst_f0",    BUS_W'(out_data[31:0]), BUS_W'(32'h13));
    chk("rst_f1",    BUS_W'(out_data[63:32]), '0);
    chk("rst_cnt",   BUS_W'(stall_cnt), '0);

    // Streaming at full rate
    step(1, word(32'h100), 1, 0, 0);
    chk("stream0", BUS_W'(out_data[31:0]), BUS_W'(32'h100));
    chk("stream0_pc4", BUS_W'(out_data[63:32]), BUS_W'(32'h104));
    step(1, word(32'h104), 1, 0, 0);
    chk("stream1", BUS_W'(out_data[31:0]), BUS_W'(32'h104));
    step(1, word(32'h108), 1, 0, 0);
    chk("stream2", BUS_W'(out_data[31:0]), BUS_W'(32'h108));
    chk("stream2_valid", BUS_W'(out_valid), BUS_W'(1));
    step(0, word(32'h108), 1, 0, 0);
    chk("stream_end_valid", BUS_W'(out_valid), '0);

    // Stall with skid fill, then drain in order
    step(1, word(32'hA), 0, 0, 0);
    step(1, word(32'hB), 0, 0, 0);
    chk("skid_ready_low", BUS_W'(out_ready), '0);
    step(0, word(32'hB), 0, 0, 0);
    step(0, word(32'hB), 0, 0, 0);
    chk("stall_hold_a", BUS_W'(out_data[31:0]), BUS_W'(32'hA));
    chk("stall_cnt3",   BUS_W'(stall_cnt), BUS_W'(3));
    step(0, word(32'hB), 1, 0, 0);
    chk("drain_b",       BUS_W'(out_data[31:0]), BUS_W'(32'hB));
    chk("drain_ready",   BUS_W'(out_ready), BUS_W'(1));
    step(0, word(32'hB), 1, 0, 0);
    chk("drain_empty",   BUS_W'(out_valid), '0);

    // Flush from TWO with a simultaneous accept
    step(1, word(32'hA), 0, 0, 0);
    step(1, word(32'hB), 0, 0, 0);
    step(1, word(32'hC), 1, 1, 0);
    chk("flush_valid", BUS_W'(out_valid), '0);
    chk("flush_f0",    BUS_W'(out_data[31:0]), BUS_W'(32'h13));
    chk("flush_ready", BUS_W'(out_ready), BUS_W'(1));
    chk("flush_cnt",   BUS_W'(stall_cnt), BUS_W'(4));
    step(0, word(32'hC), 1, 0, 0);
    chk("flush_no_emit", BUS_W'(out_valid), '0);

    // Reset and flush together with data held
    step(1, word(32'hD), 0, 0, 0);
    step(1, word(32'hE), 0, 0, 0);
    step(1, word(32'hF), 0, 1, 1);
    chk("rf_valid", BUS_W'(out_valid), '0);
    chk("rf_ready", BUS_W'(out_ready), BUS_W'(1));
    chk("rf_data",  out_data, BUBBLE);
    chk("rf_cnt",   BUS_W'(stall_cnt), '0);

    // Stall counter saturation
    step(1, word(32'h200), 0, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step(0, word(32'h200), 0, 0, 0);
    chk("sat_cnt",  BUS_W'(stall_cnt), BUS_W'(CNT_SAT));
    chk("sat_data", BUS_W'(out_data[31:0]), BUS_W'(32'h200));
    step(0, word(32'h200), 1, 0, 0);

    // Randomized traffic, keeping upstream stable while back-pressured
    hold = 1'b0;
    d    = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        d = {$urandom, $urandom};
      end
      r  = ($urandom_range(0, 9) < 6);
      f  = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(v, d, r, f, rs);
      hold = v && !last_ready_pre && !f && !rs;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline register for any stage boundary of the five-stage core (F/D, D/E, E/M, M/W).
- Adds over the basic IF/ID register: valid/ready handshake, a one-entry skid buffer so stalls never drop or combinationally pass data, synchronous flush with NOP bubble insertion, and a saturating stall-cycle counter.
- Carries NUM_FIELDS payload words of DATA_W bits each; field 0 is the instruction slot.

Parameters:
- DATA_W, 32, width of each payload field.
- NUM_FIELDS, 2, number of payload fields; field 0 = instruction, field 1 = PC+4, etc.
- BUBBLE_INSTR, 32'h00000013, value driven on field 0 when no valid entry is present (addi x0,x0,0).
- CNT_W, 16, width of the stall counter.

Ports:
- iClk, in, 1, clock; all state updates on rising edge.
- iRst, in, 1, synchronous, active-high reset.
- iFlush, in, 1, synchronous flush (branch mispredict / jump).
- iValid, in, 1, upstream payload valid.
- oReady, out, 1, stage can accept; registered, not combinational from iReady.
- iData, in, NUM_FIELDS*DATA_W, upstream payload; field k occupies bits [k*DATA_W +: DATA_W].
- oValid, out, 1, downstream payload valid.
- iReady, in, 1, downstream can accept (iReady=0 is the hazard-unit stall).
- oData, out, NUM_FIELDS*DATA_W, registered payload to the next stage.
- oStallCount, out, CNT_W, cycles with oValid=1 and iReady=0.

Behaviour:
- Accept = iValid & oReady; Emit = oValid & iReady; both sampled at the rising edge.
- Latency 1 cycle input to output; sustained throughput 1 word/cycle when iReady stays high; strict FIFO order.
- All outputs registered; no combinational path from iData or iReady to any output.
- States (package enum):
  - EMPTY: main slot and skid slot empty.
  - ONE: main slot full.
  - TWO: main slot and skid slot full.
- oValid = (state != EMPTY); oReady = (state != TWO).
- Transitions (when neither reset nor flush is active):
  - EMPTY: Accept -> ONE, main <= iData.
  - ONE, Accept & Emit: stay ONE, main <= iData.
  - ONE, Accept & !Emit: -> TWO, skid <= iData, main holds.
  - ONE, !Accept & Emit: -> EMPTY.
  - ONE, neither: hold.
  - TWO, Emit: -> ONE, main <= skid.
  - TWO, !Emit: hold. No accept is possible because oReady=0.
- When oValid=0, oData is the bubble pattern: field 0 = BUBBLE_INSTR, all other fields = 0. It is loaded on every transition into EMPTY.
- Flush (iFlush=1, iRst=0):
  - Next state EMPTY; both slots are discarded and oData <= bubble.
  - An Accept in the same cycle is dropped.
  - oReady=1 and oValid=0 on the following cycle.
  - Flush has priority over Accept, Emit and stall.
  - The stall counter is NOT cleared by flush.
- Reset (iRst=1):
  - Overrides everything, including flush.
  - state=EMPTY, oValid=0, oReady=1, oData=bubble, skid contents=0, oStallCount=0.
  - Reset asserted mid-transfer discards all held data.
- Stall counter: +1 each cycle oValid & !iReady; saturates at 2^CNT_W-1 with no wrap.
- iData is ignored while iValid=0. Upstream must hold iData/iValid while iValid & !oReady; this rule is checked by assertion.

Decomposition:
- pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;
  - localparam NOP_INSTR = 32'h00000013;
  - a function bubble_word(NUM_FIELDS, DATA_W).
- One sub-module, pipe_slot: a DATA_W*NUM_FIELDS register with load enable and synchronous clear-to-bubble. It is instantiated twice, for the main slot and the skid slot.

Test Plan:
- Reset, then hold iRst=0 with iValid=0 -> oValid=0, oReady=1, oData field0=32'h00000013, field1=0, oStallCount=0.
- Stream 0x100,0x104,0x108 with iReady=1 -> each appears on oData one cycle later; oValid=1 for exactly 3 cycles; no gaps.
- Send 0xA then 0xB, drop iReady for 3 cycles -> oReady falls after 0xB enters the skid; oData holds 0xA; oStallCount=3; on iReady=1, output is 0xA then 0xB in order, and oReady returns to 1.
- Reach state TWO, pulse iFlush while iValid=1 with 0xC -> next cycle oValid=0, oData field0=0x13, oReady=1; 0xA, 0xB and 0xC never emitted; oStallCount unchanged.
- Assert iFlush and iRst together with data held -> reset values everywhere, oStallCount=0.
- Hold iReady=0 with oValid=1 for 2^CNT_W+5 cycles (CNT_W=4) -> oStallCount saturates at 15.
